hazard_ctrl: RTL and testbench

//  Central hazard controller for the 5-stage pipeline. Keeps a shadow pipeline of destination

---
 rtl/hazard_ctrl_pkg.sv | 26 ++
 rtl/hazard_ctrl_if.sv | 43 ++++
 rtl/hazard_slot.sv | 26 ++
 rtl/hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: forward selects,
// FSM states and shadow-slot field layout.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } hz_state_e;

  // slot = {wR, valid, we, load}
  localparam int SL_LOAD  = 0;
  localparam int SL_WE    = 1;
  localparam int SL_VALID = 2;
  localparam int SL_WR    = 3;

  function automatic int slot_w(int ra_w);
    return ra_w + SL_WR;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle.
// master = pipeline side, slave = controller.
interface hazard_ctrl_if #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
);
  logic [RA_W-1:0]  ID_rs1;
  logic [RA_W-1:0]  ID_rs2;
  logic             ID_rs1_used;
  logic             ID_rs2_used;
  logic [RA_W-1:0]  ID_wR;
  logic             ID_rf_we;
  logic             ID_is_load;
  logic             EX_redirect;
  logic             pc_stall;
  logic             ifid_stall;
  logic             ifid_flush;
  logic             data_hazard;
  logic             control_hazard;
  logic [1:0]       fwd_rs1_sel;
  logic [1:0]       fwd_rs2_sel;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] stall_events;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used,
    output ID_wR, ID_rf_we, ID_is_load, EX_redirect,
    input  pc_stall, ifid_stall, ifid_flush,
    input  data_hazard, control_hazard,
    input  fwd_rs1_sel, fwd_rs2_sel,
    input  stall_cycles, stall_events, flush_events
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used,
    input  ID_wR, ID_rf_we, ID_is_load, EX_redirect,
    output pc_stall, ifid_stall, ifid_flush,
    output data_hazard, control_hazard,
    output fwd_rs1_sel, fwd_rs2_sel,
    output stall_cycles, stall_events, flush_events
  );
endinterface

// File: rtl/hazard_slot.sv
// One shadow pipeline slot of destination info.
// A bubble loads an invalid (all-zero) slot.
module hazard_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_bubble,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_q <= '0;
    else if (i_bubble)
      r_q <= '0;
    else
      r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Central data/control hazard controller with perf counters.
// FORWARD_EN: forwarding with load-use bubble; else stall to WB.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave bus
);

  localparam int SW = slot_w(RA_W);

  logic [SW-1:0] w_id_slot;
  logic [SW-1:0] w_ex;
  logic [SW-1:0] w_mem;
  logic [SW-1:0] w_wb;
  logic          w_ex_bubble;
  logic          w_ctrl;
  logic          w_raw;
  logic          w_dh;
  logic [1:0]    w_sel1;
  logic [1:0]    w_sel2;
  logic          w_unused;

  hz_state_e        r_state;
  logic             r_id_valid;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_stall_events;
  logic [CNT_W-1:0] r_flush_events;

  function automatic logic hit(
    logic [RA_W-1:0] rs,
    logic            used,
    logic [SW-1:0]   s
  );
    return used && (rs != '0) && s[SL_VALID]
        && s[SL_WE] && (s[SW-1:SL_WR] == rs);
  endfunction

  assign w_id_slot = {bus.ID_wR, 1'b1,
                      bus.ID_rf_we, bus.ID_is_load};

  assign w_ex_bubble = w_dh | w_ctrl | ~r_id_valid;

  hazard_slot #(.W(SW)) u_ex (
    .clk      (clk),
    .rst      (rst),
    .i_bubble (w_ex_bubble),
    .i_d      (w_id_slot),
    .o_q      (w_ex)
  );

  hazard_slot #(.W(SW)) u_mem (
    .clk      (clk),
    .rst      (rst),
    .i_bubble (1'b0),
    .i_d      (w_ex),
    .o_q      (w_mem)
  );

  hazard_slot #(.W(SW)) u_wb (
    .clk      (clk),
    .rst      (rst),
    .i_bubble (1'b0),
    .i_d      (w_mem),
    .o_q      (w_wb)
  );

  logic w_rs1_ex, w_rs2_ex;
  logic w_rs1_mem, w_rs2_mem;

  assign w_rs1_ex  = hit(bus.ID_rs1, bus.ID_rs1_used, w_ex);
  assign w_rs2_ex  = hit(bus.ID_rs2, bus.ID_rs2_used, w_ex);
  assign w_rs1_mem = hit(bus.ID_rs1, bus.ID_rs1_used, w_mem);
  assign w_rs2_mem = hit(bus.ID_rs2, bus.ID_rs2_used, w_mem);

`ifdef FORWARD_EN
  logic w_rs1_wb, w_rs2_wb;

  function automatic logic [1:0] fwd_sel(
    logic ex, logic mem, logic wb
  );
    if (ex)  return FWD_EX;
    if (mem) return FWD_MEM;
    if (wb)  return FWD_WB;
    return FWD_RF;
  endfunction

  assign w_rs1_wb = hit(bus.ID_rs1, bus.ID_rs1_used, w_wb);
  assign w_rs2_wb = hit(bus.ID_rs2, bus.ID_rs2_used, w_wb);

  // a load in EX has no result yet: bubble, never forward
  assign w_raw  = (w_rs1_ex | w_rs2_ex) & w_ex[SL_LOAD];
  assign w_sel1 = fwd_sel(w_rs1_ex & ~w_ex[SL_LOAD],
                          w_rs1_mem, w_rs1_wb);
  assign w_sel2 = fwd_sel(w_rs2_ex & ~w_ex[SL_LOAD],
                          w_rs2_mem, w_rs2_wb);
  assign w_unused = &{1'b0, w_wb[SL_LOAD]};
`else
  // WB needs no stall: the register file writes through
  assign w_raw  = w_rs1_ex | w_rs2_ex | w_rs1_mem | w_rs2_mem;
  assign w_sel1 = FWD_RF;
  assign w_sel2 = FWD_RF;
  assign w_unused = &{1'b0, w_wb};
`endif

  assign w_ctrl = bus.EX_redirect & ~rst;
  assign w_dh   = w_raw & r_id_valid & ~w_ctrl & ~rst;

  assign bus.control_hazard = w_ctrl;
  assign bus.ifid_flush     = w_ctrl;
  assign bus.data_hazard    = w_dh;
  assign bus.pc_stall       = w_dh;
  assign bus.ifid_stall     = w_dh;
  assign bus.fwd_rs1_sel    = rst ? FWD_RF : w_sel1;
  assign bus.fwd_rs2_sel    = rst ? FWD_RF : w_sel2;
  assign bus.stall_cycles   = r_stall_cycles;
  assign bus.stall_events   = r_stall_events;
  assign bus.flush_events   = r_flush_events;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_RUN;
      r_id_valid     <= 1'b0;
      r_stall_cycles <= '0;
      r_stall_events <= '0;
      r_flush_events <= '0;
    end else begin
      if (w_ctrl)
        r_id_valid <= 1'b0;
      else if (!w_dh)
        r_id_valid <= 1'b1;

      if (w_ctrl) begin
        r_state <= ST_FLUSH;
      end else begin
        unique case (r_state)
          ST_RUN:   if (w_dh) r_state <= ST_STALL;
          ST_STALL: if (!w_dh) r_state <= ST_RUN;
          ST_FLUSH: r_state <= w_dh ? ST_STALL : ST_RUN;
          default:  r_state <= ST_RUN;
        endcase
      end

      if (w_dh && !(&r_stall_cycles))
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (w_dh && (r_state != ST_STALL) && !(&r_stall_events))
        r_stall_events <= r_stall_events + CNT_W'(1);
      if (w_ctrl && !(&r_flush_events))
        r_flush_events <= r_flush_events + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (4-bit counters to reach saturation).
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  hazard_ctrl_if #(.RA_W(5), .CNT_W(4)) bus ();

  hazard_ctrl #(.RA_W(5), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2,
                     input logic [4:0] wr, input logic we,
                     input logic ld);
    bus.ID_rs1      = rs1;
    bus.ID_rs1_used = u1;
    bus.ID_rs2      = rs2;
    bus.ID_rs2_used = u2;
    bus.ID_wR       = wr;
    bus.ID_rf_we    = we;
    bus.ID_is_load  = ld;
  endtask

  task automatic nop();
    drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    nop();
    bus.EX_redirect = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // producer x7 then consumer rs1=x7, rs2=x0, from a fresh reset
  task automatic dep_pair(input bit ld, input string tag);
    int n_exp;
    int sel_exp;
    n_exp   = !FWD ? 2 : (ld ? 1 : 0);
    sel_exp = !FWD ? 0 : (ld ? 2 : 1);
    nop();
    tick();
    drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, ld);
    @(negedge clk);
    chk({tag, "_prod_dh"}, 32'(bus.data_hazard), 0);
    tick();
    drv(5'd7, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0);
    for (int c = 0; c <= n_exp; c++) begin
      @(negedge clk);
      chk({tag, "_dh"}, 32'(bus.data_hazard), 32'(c < n_exp));
      chk({tag, "_pcst"}, 32'(bus.pc_stall), 32'(c < n_exp));
      chk({tag, "_ifst"}, 32'(bus.ifid_stall), 32'(c < n_exp));
      if (c == n_exp) begin
        chk({tag, "_fwd1"}, 32'(bus.fwd_rs1_sel), 32'(sel_exp));
        chk({tag, "_fwd2"}, 32'(bus.fwd_rs2_sel), 0);
      end
      tick();
    end
    nop();
    chk({tag, "_scyc"}, 32'(bus.stall_cycles), 32'(n_exp));
    chk({tag, "_sevt"}, 32'(bus.stall_events), 32'(n_exp != 0));
  endtask

  initial begin
    int g;
    logic h;

    do_reset();
    chk("rst_state", 32'(dut.r_state), 0);
    chk("rst_scyc", 32'(bus.stall_cycles), 0);
    chk("rst_fevt", 32'(bus.flush_events), 0);

    // test 1: reset asserted mid-stall
    nop();
    tick();
    drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    tick();
    drv(5'd7, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    @(negedge clk);
    chk("t1_pre_dh", 32'(bus.data_hazard), 1);
    bus.EX_redirect = 1'b1;
    rst = 1'b1;
    #1;
    chk("t1_rst_dh", 32'(bus.data_hazard), 0);
    chk("t1_rst_pcst", 32'(bus.pc_stall), 0);
    chk("t1_rst_ctrl", 32'(bus.control_hazard), 0);
    chk("t1_rst_flush", 32'(bus.ifid_flush), 0);
    chk("t1_rst_fwd1", 32'(bus.fwd_rs1_sel), 0);
    bus.EX_redirect = 1'b0;
    nop();
    tick();
    rst = 1'b0;
    dep_pair(1'b1, "t1_load");

    // test 2: ALU producer/consumer
    do_reset();
    dep_pair(1'b0, "t2_alu");

    // test 3: load-use
    do_reset();
    dep_pair(1'b1, "t3_load");

    // test 4: x0 never hazards
    do_reset();
    nop();
    tick();
    drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    drv(5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0);
    @(negedge clk);
    chk("t4_dh", 32'(bus.data_hazard), 0);
    chk("t4_fwd1", 32'(bus.fwd_rs1_sel), 0);
    tick();

    // producer reaches WB: forward 11, or no stall without forwarding
    do_reset();
    nop();
    tick();
    drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    tick();
    nop();
    tick();
    tick();
    drv(5'd0, 1'b0, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0);
    @(negedge clk);
    chk("wb_dh", 32'(bus.data_hazard), 0);
    chk("wb_fwd2", 32'(bus.fwd_rs2_sel), FWD ? 3 : 0);
    tick();

    // two producers of x4: EX wins over MEM
    do_reset();
    nop();
    tick();
    drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    tick();
    tick();
    drv(5'd4, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    @(negedge clk);
    chk("pri_dh", 32'(bus.data_hazard), FWD ? 0 : 1);
    chk("pri_fwd1", 32'(bus.fwd_rs1_sel), FWD ? 1 : 0);
    tick();

    // test 5: redirect beats a pending load-use stall
    do_reset();
    nop();
    tick();
    drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    tick();
    drv(5'd7, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    bus.EX_redirect = 1'b1;
    @(negedge clk);
    chk("t5_ctrl", 32'(bus.control_hazard), 1);
    chk("t5_flush", 32'(bus.ifid_flush), 1);
    chk("t5_dh", 32'(bus.data_hazard), 0);
    chk("t5_pcst", 32'(bus.pc_stall), 0);
    tick();
    bus.EX_redirect = 1'b0;
    chk("t5_fevt", 32'(bus.flush_events), 1);
    chk("t5_st_flush", 32'(dut.r_state), 2);
    chk("t5_sevt", 32'(bus.stall_events), 0);
    @(negedge clk);
    chk("t5_post_dh", 32'(bus.data_hazard), 0);
    chk("t5_post_flush", 32'(bus.ifid_flush), 0);
    tick();
    chk("t5_st_run", 32'(dut.r_state), 0);
    chk("t5_fevt2", 32'(bus.flush_events), 1);

    // test 6a: flush counter saturates
    do_reset();
    bus.EX_redirect = 1'b1;
    repeat (15) tick();
    chk("t6_fevt_15", 32'(bus.flush_events), 15);
    tick();
    chk("t6_fevt_sat", 32'(bus.flush_events), 15);
    bus.EX_redirect = 1'b0;

    // test 6b: stall counters saturate
    do_reset();
    nop();
    tick();
    for (int it = 0; it < 18; it++) begin
      drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
      tick();
      drv(5'd7, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
      g = 0;
      do begin
        @(negedge clk);
        h = bus.data_hazard;
        tick();
        g++;
      end while (h && g < 8);
      if (g >= 8) chk("t6_bound", 32'(g), 0);
    end
    nop();
    tick();
    chk("t6_scyc_sat", 32'(bus.stall_cycles), 15);
    chk("t6_sevt_sat", 32'(bus.stall_events), 15);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 exp 1");
    $fatal(1, "timeout");
  end

endmodule
